priority_decoder_seq: RTL
=========================

Name: priority_decoder_seq

Overview:
- Decoder end of the 4-to-2 priority encoder interface.
- Accepts a stream of encoded codes {x, y, v} on a valid/ready handshake.
- Drives a one-hot 4-bit strobe d_out for HOLD_CYCLES clocks per code, followed by a GAP_CYCLES quiet interval.
- A one-entry pending register absorbs one code while a strobe is in progress.
- Used to regenerate request lines from encoded priority codes, e.g. in loopback of the encoder.

Parameters:
- HOLD_CYCLES, 4, clocks d_out stays asserted per code; legal range 1..255.
- GAP_CYCLES, 1, clocks of d_out=0000 between consecutive strobes; legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  code present on x/y/v.
- in_ready  output  1  block can accept a code this cycle.
- x  input  1  code MSB.
- y  input  1  code LSB.
- v  input  1  code valid flag; 0 means the encoder saw no request.
- d_out  output  4  one-hot decoded strobe, registered.
- d_valid  output  1  high whenever d_out is non-zero.
- busy  output  1  FSM not in IDLE, or pending register occupied.
- drop_cnt  output  8  count of accepted codes with v=0; saturates at 255.

Behaviour:
- Reset is asynchronous and active-low.
  - Values while rst_n=0: state=IDLE, d_out=0000, d_valid=0, busy=0, drop_cnt=0, pending empty, counter=0.
  - While rst_n=0, in_ready=1.
  - Asserting rst_n mid-strobe aborts the strobe immediately and discards the pending code.
- Decode map, applied when v=1:
  - {x,y}=11 -> 1000
  - {x,y}=10 -> 0100
  - {x,y}=01 -> 0010
  - {x,y}=00 -> 0001
- Handshake:
  - A transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = !pend_valid, registered-state based, with no combinational path from in_valid.
- v=0 codes:
  - Still accepted.
  - Never stored, never strobed.
  - drop_cnt += 1, saturating at 255.
- FSM states are IDLE, HOLD and GAP.
  - IDLE: a transfer with v=1 -> HOLD. d_out = decoded value from the next cycle, giving 1-cycle latency. Counter is loaded with HOLD_CYCLES-1.
  - HOLD: counter decrements each clock. At counter==0:
    - -> GAP if GAP_CYCLES>0, with counter = GAP_CYCLES-1 and d_out=0000.
    - Otherwise, if pending is valid -> HOLD with the pending code, and pending is cleared.
    - Otherwise -> IDLE.
  - GAP: d_out=0000 and the counter decrements. At 0 -> HOLD with the pending code if pending is valid, else -> IDLE.
- Transfer while not IDLE:
  - A v=1 code goes into the pending register. in_ready drops on the next cycle.
  - A second code is back-pressured.
- Simultaneous pending drain and new input:
  - This cannot occur, because in_ready=0 while pending is valid.
  - The new code is accepted the cycle after the drain.
- Back-to-back strobes with GAP_CYCLES=0 must not insert a 0000 cycle between them.
- Counter width is 8 bits; parameters outside the legal range are unsupported.

Optional Feature:
- Macro: PRIO_DEC_ERR_EN.
- Defined:
  - Adds output err (1 bit).
  - err is set on any accepted code with v=0 and {x,y}!=00, i.e. a malformed encoder output.
  - err is sticky and cleared only by rst_n.
  - Reset value 0.
- Undefined:
  - The err port and its logic are absent.
  - Malformed v=0 codes are dropped and counted in drop_cnt exactly as other v=0 codes.

Decomposition:
- Shared package prio_enc_pkg holds:
  - the state enum (IDLE, HOLD, GAP);
  - the one-hot constants D_P3=4'b1000, D_P2=4'b0100, D_P1=4'b0010, D_P0=4'b0001;
  - the code width constant CODE_W=2.
- Sub-module prio_code_to_onehot: combinational {x,y} -> 4-bit one-hot. It is reusable for encoder/decoder loopback checks.

Test Plan:
- Reset then single code x=1,y=1,v=1 with HOLD=4, GAP=1 -> d_out=1000 for exactly 4 cycles starting 1 cycle after accept, then 0000. busy falls after the gap.
- Codes 10 then 01 sent back-to-back -> d_out=0100 ×4, 0000 ×1, 0010 ×4. The second code sits in pending, and in_ready is low for exactly one stretch while pending is occupied.
- 300 codes with v=0 -> d_out stays 0000 and drop_cnt saturates at 255.
  - With PRIO_DEC_ERR_EN: a v=0 code with x=1,y=0 sets err=1, and err stays 1 until reset.
- GAP_CYCLES=0, codes 00 and 11 -> d_out 0001 ×4 immediately followed by 1000 ×4, with no 0000 cycle between.
- rst_n pulsed low during the HOLD of 0100 with a code pending -> d_out=0000 asynchronously. After release, state is IDLE, pending is empty, and in_ready=1.
- Encoder loopback with D=0000, 1000, 1011, 0101, 0001 -> d_out=0000 (dropped), then 1000, 1000, 0100, 0001, in order.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared types and constants for the priority encoder/decoder pair.
package prio_enc_pkg;

  localparam int CODE_W = 2;
  localparam int CNT_W  = 8;

  localparam logic [3:0] D_P3 = 4'b1000;
  localparam logic [3:0] D_P2 = 4'b0100;
  localparam logic [3:0] D_P1 = 4'b0010;
  localparam logic [3:0] D_P0 = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_e;

  typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/prio_code_to_onehot.sv
// Combinational {x,y} -> one-hot map; shared by decoder and loopback checkers.
module prio_code_to_onehot
  import prio_enc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [3:0]        onehot
);

  always_comb begin
    case (code)
      2'b11:   onehot = D_P3;
      2'b10:   onehot = D_P2;
      2'b01:   onehot = D_P1;
      default: onehot = D_P0;
    endcase
  end

endmodule

// File: rtl/priority_decoder_seq.sv
// Sequential priority decoder: turns {x,y,v} codes into timed one-hot strobes.
// Optional sticky malformed-code flag `err` when PRIO_DEC_ERR_EN is defined.
module priority_decoder_seq
  import prio_enc_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       x,
  input  logic       y,
  input  logic       v,
  output logic [3:0] d_out,
  output logic       d_valid,
  output logic       busy,
  output logic [7:0] drop_cnt
`ifdef PRIO_DEC_ERR_EN
  ,
  output logic       err
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       d_out_q, d_out_d;
  logic             pend_valid_q, pend_valid_d;
  code_t            pend_code_q, pend_code_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  code_t      in_code;
  code_t      sel_code;
  logic [3:0] sel_onehot;
  logic       accept;
  logic       acc_code;
  logic       start;
  logic       take_new;
  logic       finish;

  assign in_code  = {x, y};
  assign accept   = in_valid && in_ready;
  assign acc_code = accept && v;
  // A pending code always wins over a fresh one when a strobe slot opens.
  assign sel_code = pend_valid_q ? pend_code_q : in_code;

  prio_code_to_onehot u_onehot (
    .code   (sel_code),
    .onehot (sel_onehot)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      d_out_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      d_out_q      <= d_out_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    d_out_d      = d_out_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    start        = 1'b0;
    take_new     = 1'b0;
    finish       = 1'b0;

    case (state_q)
      IDLE: begin
        if (acc_code) begin
          start    = 1'b1;
          take_new = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
          d_out_d = '0;
        end else begin
          finish = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          finish = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        d_out_d = '0;
      end
    endcase

    // End of a strobe slot: chain straight into the next code, if any.
    if (finish) begin
      if (pend_valid_q) begin
        start        = 1'b1;
        pend_valid_d = 1'b0;
      end else if (acc_code) begin
        start    = 1'b1;
        take_new = 1'b1;
      end else begin
        state_d = IDLE;
        d_out_d = '0;
      end
    end

    if (start) begin
      state_d = HOLD;
      cnt_d   = HOLD_LD;
      d_out_d = sel_onehot;
    end

    if (acc_code && !take_new) begin
      pend_valid_d = 1'b1;
      pend_code_d  = in_code;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && !v && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Output logic: all derived from registered state only
  always_comb begin
    in_ready = !pend_valid_q;
    d_valid  = |d_out_q;
    busy     = (state_q != IDLE) || pend_valid_q;
    d_out    = d_out_q;
    drop_cnt = drop_cnt_q;
  end

`ifdef PRIO_DEC_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q || (accept && !v && (in_code != '0));
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`endif

endmodule
